// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the parametrised sequence detector:
// detection-mode encoding and a ceiling-log2 helper for derived widths.
package csm51a_seq_pkg;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  // Ceiling log2, used for state and prefix-length widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Symbol-stream bus of the sequence detector: symbol input, pattern
// programming and the registered detection results.
interface seq_detect_param_if
  import csm51a_seq_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int ST_W = clog2(DEPTH);

  logic                   x_valid;
  logic [SYM_W-1:0]       x;
  logic                   pattern_load;
  logic [DEPTH*SYM_W-1:0] pattern_in;
  logic                   overlap;
  logic                   z;
  logic [CNT_W-1:0]       z_count;
  logic [ST_W-1:0]        pstate;

  // Symbol source side.
  modport master (
    output x_valid, x, pattern_load, pattern_in, overlap,
    input  z, z_count, pstate
  );

  // Detector side.
  modport slave (
    input  x_valid, x, pattern_load, pattern_in, overlap,
    output z, z_count, pstate
  );

endinterface

// File: rtl/seq_detect_param_prefix_match.sv
// Combinational prefix matcher: finds the longest pattern prefix ending in
// the incoming symbol (bounded by the valid history depth) and the longest
// proper border of the pattern, which is where overlap detection resumes.
module seq_prefix_match
  import csm51a_seq_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4,
  parameter int ST_W  = clog2(DEPTH),
  parameter int K_W   = clog2(DEPTH + 1)
) (
  input  logic [DEPTH*SYM_W-1:0]     pattern,
  input  logic [(DEPTH-1)*SYM_W-1:0] hist,
  input  logic [ST_W-1:0]            fill,
  input  logic [SYM_W-1:0]           s,
  output logic [K_W-1:0]             k_new,
  output logic [ST_W-1:0]            fallback
);
  logic [SYM_W-1:0] pat_a  [DEPTH];
  logic [SYM_W-1:0] hist_a [DEPTH-1];
  logic             match_ok_s;
  logic             border_ok_s;

  // Unpack pattern (index 0 = first expected) and history (index 0 = newest).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pat_a[i] = pattern[i*SYM_W +: SYM_W];
    end
    for (int j = 0; j < DEPTH - 1; j++) begin
      hist_a[j] = hist[j*SYM_W +: SYM_W];
    end
  end

  // Longest prefix of length k whose last symbol is s and whose first k-1
  // symbols are the k-1 most recent history symbols, oldest first.
  always_comb begin
    k_new      = '0;
    match_ok_s = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      match_ok_s = (int'(fill) >= k - 1) && (pat_a[k-1] == s);
      for (int j = 0; j < k - 1; j++) begin
        match_ok_s = match_ok_s && (pat_a[k-2-j] == hist_a[j]);
      end
      k_new = match_ok_s ? K_W'(k) : k_new;
    end
  end

  // Longest proper prefix of the pattern that is also its suffix.
  always_comb begin
    fallback    = '0;
    border_ok_s = 1'b0;
    for (int l = 1; l < DEPTH; l++) begin
      border_ok_s = 1'b1;
      for (int j = 0; j < l; j++) begin
        border_ok_s = border_ok_s && (pat_a[j] == pat_a[DEPTH-l+j]);
      end
      fallback = border_ok_s ? ST_W'(l) : fallback;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised sequence detector: holds pattern, symbol history, fill level,
// matched-prefix state and a saturating match counter. Prefix arithmetic
// lives in seq_prefix_match.
module seq_detect_param
  import csm51a_seq_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic               clock,
  input logic               clear,
  seq_detect_param_if.slave bus
);
  localparam int ST_W = clog2(DEPTH);
  localparam int K_W  = clog2(DEPTH + 1);
  localparam int HW   = (DEPTH - 1) * SYM_W;
  localparam int PW   = DEPTH * SYM_W;

  logic [PW-1:0]    pattern_r, pattern_s;
  logic [HW-1:0]    hist_r, hist_s, hist_shift_s;
  logic [ST_W-1:0]  fill_r, fill_s, fill_inc_s;
  logic [ST_W-1:0]  pstate_r, pstate_s;
  logic             z_r, z_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [K_W-1:0]   k_new_s;
  logic [ST_W-1:0]  fallback_s;

  seq_prefix_match #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .ST_W  (ST_W),
    .K_W   (K_W)
  ) u_match (
    .pattern  (pattern_r),
    .hist     (hist_r),
    .fill     (fill_r),
    .s        (bus.x),
    .k_new    (k_new_s),
    .fallback (fallback_s)
  );

  // Newest symbol enters at the low end; fill saturates at DEPTH-1.
  assign hist_shift_s = HW'({hist_r, bus.x});
  assign fill_inc_s   = (fill_r == ST_W'(DEPTH - 1)) ? fill_r : fill_r + ST_W'(1);

  // Next-state: load flushes history, accepted symbols advance the match.
  always_comb begin
    pattern_s = pattern_r;
    hist_s    = hist_r;
    fill_s    = fill_r;
    pstate_s  = pstate_r;
    cnt_s     = cnt_r;
    z_s       = 1'b0;
    if (bus.pattern_load) begin
      pattern_s = bus.pattern_in;
      fill_s    = '0;
      pstate_s  = '0;
    end else if (bus.x_valid) begin
      if (k_new_s == K_W'(DEPTH)) begin
        z_s   = 1'b1;
        cnt_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        if (bus.overlap == MODE_OVERLAP) begin
          hist_s   = hist_shift_s;
          fill_s   = fill_inc_s;
          pstate_s = fallback_s;
        end else begin
          fill_s   = '0;
          pstate_s = '0;
        end
      end else begin
        hist_s   = hist_shift_s;
        fill_s   = fill_inc_s;
        pstate_s = ST_W'(k_new_s);
      end
    end else begin
      z_s = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pattern_r <= '0;
      hist_r    <= '0;
      fill_r    <= '0;
      pstate_r  <= '0;
      z_r       <= 1'b0;
      cnt_r     <= '0;
    end else begin
      pattern_r <= pattern_s;
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      pstate_r  <= pstate_s;
      z_r       <= z_s;
      cnt_r     <= cnt_s;
    end
  end

  assign bus.z       = z_r;
  assign bus.z_count = cnt_r;
  assign bus.pstate  = pstate_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed vector table, hand-written corner
// sequences (async clear, counter saturation) and random stimulus checked
// against a queue-based reference model.
module tb_seq_detect_param;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_fail;

  seq_detect_param_if #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) bus1 ();
  seq_detect_param_if #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) bus2 ();

  seq_detect_param #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) dut (
    .clock (clock), .clear (clear), .bus (bus1.slave)
  );
  seq_detect_param #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clock (clock), .clear (clear), .bus (bus2.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       v;
    logic [1:0] x;
    logic       ld;
    logic [7:0] pin;
    logic       ov;
    logic       ez;
    logic [1:0] eps;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: pattern symbols, symbols seen since the last flush.
  logic [1:0] m_pat[4];
  logic [1:0] m_q[$];
  bit         m_z;
  int         m_ps;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void row(input logic v, input logic [1:0] x, input logic ld,
                              input logic [7:0] pin, input logic ov, input logic ez,
                              input logic [1:0] eps, input logic [7:0] ecnt);
    vec_t r;
    r.v = v; r.x = x; r.ld = ld; r.pin = pin; r.ov = ov;
    r.ez = ez; r.eps = eps; r.ecnt = ecnt;
    tbl.push_back(r);
  endfunction

  // Longest k <= maxk such that the last k stream symbols equal pattern[0..k-1].
  function automatic int longest(input int maxk);
    int n;
    int best;
    bit ok;
    n = m_q.size();
    best = 0;
    for (int k = 1; k <= maxk && k <= n; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (m_q[n-k+i] !== m_pat[i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_pat[i] = 2'd0;
    m_q.delete();
    m_z = 1'b0;
    m_ps = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [1:0] x, input logic ld,
                                     input logic [7:0] pin, input logic ov);
    int k;
    m_z = 1'b0;
    if (ld) begin
      for (int i = 0; i < 4; i++) m_pat[i] = pin[2*i +: 2];
      m_q.delete();
      m_ps = 0;
    end else if (v) begin
      m_q.push_back(x);
      k = longest(4);
      if (k == 4) begin
        m_z = 1'b1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (ov) begin
          m_ps = longest(3);
        end else begin
          m_q.delete();
          m_ps = 0;
        end
      end else begin
        m_ps = k;
      end
      while (m_q.size() > 3) void'(m_q.pop_front());
    end
  endfunction

  task automatic apply(input logic v, input logic [1:0] x, input logic ld,
                       input logic [7:0] pin, input logic ov);
    bus1.x_valid = v;
    bus1.x = x;
    bus1.pattern_load = ld;
    bus1.pattern_in = pin;
    bus1.overlap = ov;
    @(posedge clock);
    #1;
    model_step(v, x, ld, pin, ov);
  endtask

  task automatic chk_out(input string tag, input logic ez, input logic [1:0] eps,
                         input logic [7:0] ecnt);
    chk({tag, "_z"}, 32'(bus1.z), 32'(ez));
    chk({tag, "_pstate"}, 32'(bus1.pstate), 32'(eps));
    chk({tag, "_count"}, 32'(bus1.z_count), 32'(ecnt));
  endtask

  initial begin
    logic [7:0] rpin;
    n_checks = 0;
    n_fail = 0;
    clear = 1'b1;
    bus1.x_valid = 1'b0; bus1.x = 2'd0; bus1.pattern_load = 1'b0;
    bus1.pattern_in = 8'h00; bus1.overlap = 1'b1;
    bus2.x_valid = 1'b0; bus2.x = 2'd0; bus2.pattern_load = 1'b0;
    bus2.pattern_in = 8'h00; bus2.overlap = 1'b1;
    model_reset();
    #1 clear = 1'b0;

    // Reset held with random symbols offered.
    for (int i = 0; i < 3; i++) begin
      bus1.x_valid = 1'b1;
      bus1.x = 2'($urandom_range(0, 3));
      @(posedge clock);
      #1;
      chk_out("reset_hold", 1'b0, 2'd0, 8'd0);
    end
    #2 clear = 1'b1;

    // Directed vectors: v, x, ld, pin, ov, exp z, exp pstate, exp count.
    row(1'b0, 2'd0, 1'b1, 8'hE4, 1'b1, 1'b0, 2'd0, 8'd0);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'd0);
    row(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd0);
    row(1'b1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'd0);
    row(1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'd1);
    row(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'd1);
    row(1'b0, 2'd0, 1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 8'd1);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'd1);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd1);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'd1);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'd2);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'd3);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'd4);
    row(1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'd4);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'd4);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 8'd4);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'd4);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 8'd5);
    row(1'b0, 2'd0, 1'b1, 8'h10, 1'b1, 1'b0, 2'd0, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd5);
    row(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'd5);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'd6);
    row(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'd6);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd6);
    row(1'b0, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd6);
    row(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd6);
    row(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'd6);
    row(1'b1, 2'd0, 1'b1, 8'h10, 1'b1, 1'b0, 2'd0, 8'd6);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'd6);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'd6);
    row(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'd6);
    row(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'd7);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].x, tbl[i].ld, tbl[i].pin, tbl[i].ov);
      chk_out($sformatf("vec%0d", i), tbl[i].ez, tbl[i].eps, tbl[i].ecnt);
    end

    // Async clear while pstate=3 and z=1.
    apply(1'b0, 2'd0, 1'b1, 8'h00, 1'b1);
    apply(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
    apply(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
    apply(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
    apply(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
    chk_out("pre_clear", 1'b1, 2'd3, 8'd8);
    #2 clear = 1'b0;
    #1;
    chk_out("async_clear", 1'b0, 2'd0, 8'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      bus1.x_valid = 1'b1;
      bus1.x = 2'($urandom_range(0, 3));
      @(posedge clock);
      #1;
      chk_out("clear_hold", 1'b0, 2'd0, 8'd0);
    end
    #2 clear = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, 2'd0, 1'b0, 8'h00, 1'b1);
      chk_out($sformatf("post_clear%0d", i), (i == 4) ? 1'b1 : 1'b0,
              (i == 4) ? 2'd3 : 2'(i), (i == 4) ? 8'd1 : 8'd0);
    end

    // Saturating counter on the CNT_W=2 instance.
    bus2.pattern_load = 1'b1;
    bus2.pattern_in = 8'h00;
    bus2.overlap = 1'b1;
    bus2.x_valid = 1'b0;
    apply(1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
    bus2.pattern_load = 1'b0;
    bus2.x_valid = 1'b1;
    bus2.x = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      apply(1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("sat_z%0d", i), 32'(bus2.z), (i >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("sat_count%0d", i), 32'(bus2.z_count),
          (i <= 3) ? 32'd0 : ((i - 3 > 3) ? 32'd3 : 32'(i - 3)));
    end
    bus2.x_valid = 1'b0;

    // Random stimulus against the reference model.
    rpin = 8'h00;
    for (int i = 0; i < 4; i++) rpin[2*i +: 2] = 2'($urandom_range(0, 1));
    apply(1'b0, 2'd0, 1'b1, rpin, 1'b1);
    for (int c = 0; c < 800; c++) begin
      logic       v;
      logic [1:0] x;
      logic       ld;
      logic       ov;
      v  = ($urandom_range(0, 4) != 0);
      x  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ld = ($urandom_range(0, 39) == 0);
      ov = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) rpin[2*i +: 2] = 2'($urandom_range(0, 1));
      apply(v, x, ld, rpin, ov);
      chk($sformatf("rnd%0d_z", c), 32'(bus1.z), 32'(m_z));
      chk($sformatf("rnd%0d_pstate", c), 32'(bus1.pstate), 32'(m_ps));
      chk($sformatf("rnd%0d_count", c), 32'(bus1.z_count), 32'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised sequence-detector FSM: consumes a stream of SYM_W-bit input symbols and flags each completion of a programmable DEPTH-symbol pattern. It supports both overlapping and non-overlapping detection, and reports the present state (matched-prefix length) and a saturating match count. It is the generalised successor of the fixed 2-bit-input / 2-bit-state detector and sits directly behind the input-symbol source in lab-style datapaths.

## Interface
- SYM_W, 2, bits per input symbol
- DEPTH, 4, pattern length in symbols (≥2)
- CNT_W, 8, width of saturating match counter
- ST_W, $clog2(DEPTH), width of pstate (derived, not overridden)

- clock  in  1  single clock, rising edge
- clear  in  1  reset; asynchronous, active-low; one clock domain only
- x_valid  in  1  symbol on x is accepted this edge
- x  in  SYM_W  input symbol
- pattern_load  in  1  latch pattern_in, flush history
- pattern_in  in  DEPTH*SYM_W  pattern; symbol 0 (first expected) in bits [SYM_W-1:0]
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted symbol
- z  out  1  match pulse, one cycle
- z_count  out  CNT_W  matches since reset, saturating
- pstate  out  ST_W  current matched-prefix length, 0..DEPTH-1

## Operation
- Internal state: pattern register, history shift register (last DEPTH-1 accepted symbols), fill count (0..DEPTH-1), pstate.
- Reset (clear low, async): pattern=0, history=0, fill=0, pstate=0, z=0, z_count=0. Held while clear low.
- pattern_load=1: pattern←pattern_in, fill←0, pstate←0, z←0. x_valid on the same edge is discarded. z_count is not cleared.
- Accepted symbol s (x_valid=1, pattern_load=0):
  - Compute k_new = max k in 1..DEPTH such that k-1 ≤ fill and (last k-1 history symbols, then s) equals pattern symbols 0..k-1. k_new=0 if none.
  - k_new<DEPTH: pstate←k_new; z←0; history shifts in s; fill←min(fill+1, DEPTH-1).
  - k_new=DEPTH (match): z←1; z_count←z_count+1, saturating at 2^CNT_W-1.
    - overlap=1: history shifts in s; pstate←longest proper prefix of pattern that is a suffix of the DEPTH symbols just matched (0..DEPTH-1).
    - overlap=0: fill←0, pstate←0.
- x_valid=0: all state holds; z←0.
- Mismatch fallback is exact (longest prefix-suffix), not reset-to-zero.

## Timing
- All outputs registered. z, pstate, z_count update on the edge that accepts the completing symbol and are visible the following cycle.
- z is high for exactly one cycle per match. Back-to-back matches in overlap mode give consecutive z cycles.
- Latency from completing symbol edge to z: 0 extra cycles beyond the register.
- Asynchronous clear overrides everything mid-operation. First accepted symbol is on the first rising edge after release.
- No backpressure: every symbol with x_valid=1 is consumed.

## Structure
- Shared package/include csm51a_seq_pkg: MODE_NONOVERLAP=1'b0, MODE_OVERLAP=1'b1, clog2 helper for ST_W.
- One combinational sub-module seq_prefix_match: inputs pattern, history, fill, s; outputs k_new and the overlap fallback length. The top holds registers and the counter only.

## Test plan
SYM_W=2 and DEPTH=4 throughout; pattern_in=8'hE4 means the sequence 0,1,2,3.
- Reset: hold clear=0 with random x -> z=0, z_count=0, pstate=0. Release, then feed 0,1,2,3 with 8'hE4 loaded -> pstate 1,2,3, then z=1 for one cycle, z_count=1, pstate=0.
- Overlap: pattern 0,0,0,0 (8'h00), overlap=1, feed six 0s -> z on symbols 4, 5 and 6, z_count=3, pstate stays 3 after each match. Same stream with overlap=0 -> z on symbol 4 only, pstate 1,2 after symbols 5 and 6.
- Fallback: pattern 0,0,1,0 (8'h10), overlap=1, feed 0,0,0,1,0 -> pstate 1,2,2,3, then z on the fifth symbol and pstate=1.
- Gaps and load collision: insert x_valid=0 cycles mid-pattern -> pstate holds, z=0. Assert pattern_load together with x_valid -> symbol ignored, pstate=0, z_count unchanged.
- Saturation: CNT_W=2, 5 matches -> z_count sticks at 3 while z still pulses.
- Reset mid-operation: drop clear asynchronously (between edges) while pstate=3 -> pstate, z and z_count go to 0 immediately. Pattern becomes 0, so four 0 symbols after release produce a match.
